// File: rtl/wc_pkg.sv
// Shared types and default sizing for the WC_5_4 tile sequencer.
package wc_pkg;

    localparam int unsigned WC_DW       = 10;
    localparam int unsigned WC_N_G      = 4;
    localparam int unsigned WC_N_D      = 8;
    localparam int unsigned WC_N_Z      = 5;
    localparam int unsigned WC_CORE_LAT = 6;
    localparam int unsigned WC_IW       = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_G  = 3'd1,
        LOAD_D  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } wc_state_e;

endpackage

// File: rtl/wc_tile_sequencer.sv
// Loads kernel taps and one input tile into the WC_5_4 core, waits out its latency,
// then drains the output tile as a valid/ready stream. One tile in flight at a time.
module wc_tile_sequencer
    import wc_pkg::*;
#(
    parameter int unsigned DW       = WC_DW,
    parameter int unsigned N_G      = WC_N_G,
    parameter int unsigned N_D      = WC_N_D,
    parameter int unsigned N_Z      = WC_N_Z,
    parameter int unsigned CORE_LAT = WC_CORE_LAT,
    parameter int unsigned IW       = WC_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          cfg_reload,
    output logic          core_ld_en,
    output logic          core_ld_kernel,
    output logic [IW-1:0] core_ld_idx,
    output logic [DW-1:0] core_ld_data,
    output logic          core_start,
    output logic [IW-1:0] core_z_idx,
    input  logic [DW-1:0] core_z_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [15:0]   tile_cnt
);

    // Shared counter must index every load/drain slot and also count out the core latency.
    localparam int unsigned LAT_W = $clog2(CORE_LAT);
    localparam int unsigned CW    = (IW > LAT_W) ? IW : LAT_W;

    wc_state_e     state;
    logic [CW-1:0] cnt;
    logic          kvalid;

    logic          in_hs_c;
    logic          out_hs_c;
    logic          tile_done_c;

    assign in_ready       = (state == LOAD_G) || (state == LOAD_D);
    assign core_ld_en     = in_ready && in_valid;
    assign core_ld_kernel = (state == LOAD_G);
    assign core_ld_idx    = in_ready ? IW'(cnt) : '0;
    assign core_ld_data   = in_data;
    assign out_valid      = (state == DRAIN);
    assign core_z_idx     = out_valid ? IW'(cnt) : '0;
    assign out_data       = core_z_data;
    assign busy           = (state != IDLE);

    assign in_hs_c     = in_valid && in_ready;
    assign out_hs_c    = out_valid && out_ready;
    assign tile_done_c = out_hs_c && (cnt == CW'(N_Z - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            kvalid     <= 1'b0;
            tile_cnt   <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            tile_cnt   <= tile_cnt + 16'(tile_done_c);
            case (state)
                IDLE: begin
                    // Word is only observed here; consumption starts next cycle.
                    if (in_valid) begin
                        state <= (!kvalid || cfg_reload) ? LOAD_G : LOAD_D;
                    end
                end
                LOAD_G: begin
                    if (in_hs_c) begin
                        if (cnt == CW'(N_G - 1)) begin
                            cnt    <= '0;
                            kvalid <= 1'b1;
                            state  <= LOAD_D;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (in_hs_c) begin
                        if (cnt == CW'(N_D - 1)) begin
                            cnt        <= '0;
                            core_start <= 1'b1;
                            state      <= COMPUTE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (cnt == CW'(CORE_LAT - 1)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (out_hs_c) begin
                        if (cnt == CW'(N_Z - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wc_tile_sequencer.sv
// Directed bench for wc_tile_sequencer with a combinational core output model.
module tb_wc_tile_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        cfg_reload;
    logic        core_ld_en;
    logic        core_ld_kernel;
    logic [3:0]  core_ld_idx;
    logic [9:0]  core_ld_data;
    logic        core_start;
    logic [3:0]  core_z_idx;
    logic [9:0]  core_z_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        busy;
    logic [15:0] tile_cnt;

    int checks = 0;
    int errors = 0;

    wc_tile_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .cfg_reload    (cfg_reload),
        .core_ld_en    (core_ld_en),
        .core_ld_kernel(core_ld_kernel),
        .core_ld_idx   (core_ld_idx),
        .core_ld_data  (core_ld_data),
        .core_start    (core_start),
        .core_z_idx    (core_z_idx),
        .core_z_data   (core_z_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .tile_cnt      (tile_cnt)
    );

    // Core model: output word is a fixed tag concatenated with the selected index.
    assign core_z_data = {6'h2B, core_z_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word (after an optional in_valid gap) and check the core write on acceptance.
    task automatic push(input logic [9:0] d, input bit kern, input int idx, input int gap,
                        output int waited);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            #1;
            chk("gap_no_ld", 32'(core_ld_en), 32'd0);
            chk("gap_idx_hold", 32'(core_ld_idx), 32'(idx));
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && guard < 20) begin
            chk("idle_no_ld", 32'(core_ld_en), 32'd0);
            @(negedge clk);
            #1;
            guard++;
        end
        chk("ld_accept", 32'(in_ready), 32'd1);
        chk("ld_en", 32'(core_ld_en), 32'd1);
        chk("ld_kernel", 32'(core_ld_kernel), 32'(kern));
        chk("ld_idx", 32'(core_ld_idx), 32'(idx));
        chk("ld_data", 32'(core_ld_data), 32'(d));
        waited = guard;
        @(negedge clk);
    endtask

    task automatic load_tile(input bit kern, input int gap_at, input logic [9:0] base);
        int w;
        if (kern) begin
            for (int i = 0; i < 4; i++) begin
                push(10'(base + 10'(i)), 1'b1, i, 0, w);
                chk("g_bubble", 32'(w), (i == 0) ? 32'd1 : 32'd0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            push(10'(base + 10'h40 + 10'(i)), 1'b0, i, (i == gap_at) ? 2 : 0, w);
            chk("d_bubble", 32'(w), (i == 0 && !kern) ? 32'd1 : 32'd0);
        end
    endtask

    // Entered on the first COMPUTE cycle; checks start pulse, latency and ordered drain.
    task automatic finish_tile(input int stall_at, input bit reload_pulse, input logic [15:0] tc_exp);
        int n;
        in_valid = 1'b0;
        #1;
        chk("start_pulse", 32'(core_start), 32'd1);
        chk("cmp_in_ready", 32'(in_ready), 32'd0);
        chk("cmp_busy", 32'(busy), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            chk("start_once", 32'(core_start), 32'd0);
        end while (!out_valid && n < 20);
        chk("latency", 32'(n), 32'd6);
        for (int k = 0; k < 5; k++) begin
            cfg_reload = reload_pulse && (k == 1);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_zidx", 32'(core_z_idx), 32'(k));
                    chk("stall_data", 32'(out_data), 32'({6'h2B, 4'(k)}));
                    @(negedge clk);
                    #1;
                end
            end
            out_ready = 1'b1;
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("z_idx", 32'(core_z_idx), 32'(k));
            chk("out_data", 32'(out_data), 32'({6'h2B, 4'(k)}));
            @(negedge clk);
            #1;
        end
        cfg_reload = 1'b0;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd0);
        chk("tile_cnt", 32'(tile_cnt), 32'(tc_exp));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_reload = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ld_en", 32'(core_ld_en), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_idx", 32'(core_ld_idx), 32'd0);
        chk("rst_z_idx", 32'(core_z_idx), 32'd0);
        chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Tile 1: first tile after reset loads the kernel.
        load_tile(1'b1, -1, 10'h100);
        finish_tile(-1, 1'b0, 16'd1);

        // Tile 2: kernel persists, data only.
        @(negedge clk);
        load_tile(1'b0, -1, 10'h200);
        finish_tile(-1, 1'b0, 16'd2);

        // Tile 3: reload requested in IDLE; reload pulse during drain is ignored.
        @(negedge clk);
        cfg_reload = 1'b1;
        load_tile(1'b1, -1, 10'h080);
        cfg_reload = 1'b0;
        finish_tile(-1, 1'b1, 16'd3);

        // Tile 4: no kernel; in_valid gap during LOAD_D and output backpressure on word 2.
        @(negedge clk);
        load_tile(1'b0, 3, 10'h300);
        finish_tile(2, 1'b0, 16'd4);

        // Tile 5: abort with reset during COMPUTE.
        @(negedge clk);
        load_tile(1'b0, -1, 10'h040);
        in_valid = 1'b0;
        #1;
        chk("abort_start_seen", 32'(core_start), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_ld_en", 32'(core_ld_en), 32'd0);
        chk("abort_start", 32'(core_start), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_ld_idx", 32'(core_ld_idx), 32'd0);
        chk("abort_z_idx", 32'(core_z_idx), 32'd0);
        chk("abort_tile_cnt", 32'(tile_cnt), 32'd0);
        chk("abort_kvalid", 32'(dut.kvalid), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        // Tile 6: kernel reload forced by the reset.
        load_tile(1'b1, -1, 10'h1C0);
        finish_tile(-1, 1'b0, 16'd1);

        // Tile 7: counter wrap from 0xFFFF.
        force dut.tile_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.tile_cnt;
        #1;
        chk("forced_tile_cnt", 32'(tile_cnt), 32'h0000_FFFF);
        @(negedge clk);
        load_tile(1'b0, -1, 10'h3A0);
        finish_tile(-1, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
